vcu_vec_engine: RTL and testbench
=================================

# vcu_vec_engine

Parametrised successor to the vector control unit. Once the host signals that it has finished writing operands, the block loads two NoOfElem-element operand vectors from block RAM into internal lane registers and executes one of four lane-parallel operations in a single cycle. It then writes the result back to BRAM and raises done. It sits between the host-write port of the BRAM and the SoC-level done/interrupt logic.

## Interface
- NoOfElem, 16: lanes per vector; 2..64.
- wordSize, 32: element and BRAM word width; fixed at 32 (4 byte enables).
- memDepthC, 32: BRAM byte-address width.
- RD_LAT, 1: BRAM read latency in cycles; 1 or 2.
- BASE_A, 0: word index of vector A.
- BASE_B, 16: word index of vector B.
- BASE_R, 32: word index of the result.
- clk  in  1  single clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- memWRTDone  in  1  host operand-write complete; start request and done handshake.
- op  in  2  operation code: 00 add, 01 sub, 10 mul (low word), 11 dot product.
- BRAMdataIn  in  wordSize  BRAM read data.
- BRAMDataOut  out  wordSize  BRAM write data.
- BRAMaddrByte  out  memDepthC  BRAM byte address, equal to word index << 2.
- BRAMWREN  out  4  byte write enables.
- BRAMENMEM  out  1  BRAM enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  operation complete.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, STORE, DONE.
- IDLE: when memWRTDone=1 is sampled, latch op and go to LOAD_A.
- LOAD_A: issue word addresses BASE_A+i for i=0..N-1 on consecutive cycles with BRAMENMEM=1. Capture BRAMdataIn into lane register A[i] RD_LAT cycles after the address for i. Leave the state after the last capture.
- LOAD_B: same as LOAD_A, using BASE_B and lane register B[i].
- EXEC: compute all lanes in one cycle.
  - add/sub/mul: R[i] = A[i] op B[i], signed.
  - dot: R[0] = sum of A[i]*B[i], using an accumulator of 2*wordSize+clog2(N) bits.
- STORE: write R[i] to BASE_R+i with BRAMWREN=4'hF and BRAMENMEM=1.
  - add/sub/mul: N cycles.
  - dot: 1 cycle, one word only.
- DONE: hold done=1 until memWRTDone=0 is sampled, then go to IDLE.
- Changes on memWRTDone or op outside IDLE/DONE are ignored.
- BRAMWREN is 0 outside STORE. BRAMDataOut is 0 when not writing.

## Timing
- Reset values: done=0, busy=0, BRAMWREN=0, BRAMENMEM=0, BRAMaddrByte=0, BRAMDataOut=0; state=IDLE.
- Lane registers are not reset.
- Cycle 0 is the IDLE cycle that samples memWRTDone=1. done rises at cycle 1 + 2·(N+RD_LAT) + 1 + S, where S=N for add/sub/mul and S=1 for dot.
  - N=16, RD_LAT=1, add: done rises at cycle 52.
- memWRTDone held high through DONE does not retrigger. A new operation needs a low-then-high sequence.
- RESET asserted mid-operation: all outputs clear immediately, any in-flight write is aborted, state returns to IDLE.
- Address counter: word index width is memDepthC-2. BASE+i wraps modulo 2^(memDepthC-2).

## Configuration
- VCU_SATURATE_EN defined:
  - add, sub and mul results saturate to [-2^31, 2^31-1].
  - dot saturates the final accumulator to the same range.
- VCU_SATURATE_EN undefined: all results wrap modulo 2^wordSize, keeping the low wordSize bits.

## Structure
- Package vcu_pkg holds:
  - op encoding enum (OP_ADD, OP_SUB, OP_MUL, OP_DOT);
  - state enum;
  - saturation limit constants;
  - accumulator-width function.
- Sub-module vcu_lane_alu: one instance per lane, combinational. Takes A, B and op; outputs the lane result and the product used by the dot reduction.
- Saturation logic lives inside vcu_lane_alu and the reduction, under the macro.

## Test plan
- add, N=16, RD_LAT=1: A[i]=i, B[i]=100 -> BRAM[32+i]=100+i; done rises at cycle 52; 16 write cycles with WREN=F.
- sub with A[0]=0x80000000, B[0]=1 -> with the macro, BRAM[32]=0x80000000; without it, BRAM[32]=0x7FFFFFFF.
- dot: A[i]=2, B[i]=3 for 16 lanes -> BRAM[32]=96; exactly one write cycle.
- RD_LAT=2, mul with A[i]=B[i]=i -> BRAM[32+i]=i²; done rises at cycle 54.
- RESET pulsed during STORE at i=5 -> all outputs 0 the same cycle; returns to IDLE; a fresh memWRTDone rising edge completes normally.
- memWRTDone held high after done -> no second run; drop low then raise -> second run starts.

Source files
------------

// File: rtl/vcu_pkg.sv
// rtl/vcu_pkg.sv - shared types, saturation limits and width helper for the vector engine
// Optional feature macro: VCU_SATURATE_EN (limits below are used only when it is defined).
package vcu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DOT = 2'b11
    } vcu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_STORE,
        ST_DONE
    } vcu_state_e;

    localparam logic [WORD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [WORD_W-1:0] SAT_MIN = 32'h8000_0000;

    // Dot-product accumulator: full product width plus headroom for n terms.
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/vcu_vec_engine_if.sv
// rtl/vcu_vec_engine_if.sv - BRAM port bundle between the vector engine and its block RAM
// Signals: BRAMdataIn (read data), BRAMDataOut (write data), BRAMaddrByte (byte address),
//          BRAMWREN (byte enables), BRAMENMEM (enable).
// Modports: master = engine side, slave = memory side.
interface vcu_vec_engine_if #(
    parameter int wordSize  = 32,
    parameter int memDepthC = 32
);
    logic [wordSize-1:0]  BRAMdataIn;
    logic [wordSize-1:0]  BRAMDataOut;
    logic [memDepthC-1:0] BRAMaddrByte;
    logic [3:0]           BRAMWREN;
    logic                 BRAMENMEM;

    modport master (
        input  BRAMdataIn,
        output BRAMDataOut, BRAMaddrByte, BRAMWREN, BRAMENMEM
    );

    modport slave (
        output BRAMdataIn,
        input  BRAMDataOut, BRAMaddrByte, BRAMWREN, BRAMENMEM
    );
endinterface

// File: rtl/vcu_lane_alu.sv
// rtl/vcu_lane_alu.sv - combinational per-lane ALU (add/sub/mul) plus full product for dot
// Ports: a_i, b_i signed lane operands; op_i operation; res_o lane result;
//        prod_o full-width signed product feeding the dot reduction.
// Macro: VCU_SATURATE_EN clamps add/sub/mul results to the signed 32-bit range; otherwise wrap.
module vcu_lane_alu
    import vcu_pkg::*;
(
    input  logic signed [WORD_W-1:0]   a_i,
    input  logic signed [WORD_W-1:0]   b_i,
    input  vcu_op_e                    op_i,
    output logic        [WORD_W-1:0]   res_o,
    output logic signed [2*WORD_W-1:0] prod_o
);

    assign prod_o = (2*WORD_W)'(a_i) * (2*WORD_W)'(b_i);

`ifdef VCU_SATURATE_EN
    logic signed [WORD_W:0] sum_w;
    logic signed [WORD_W:0] diff_w;
    logic                   mul_fits;

    assign sum_w  = (WORD_W+1)'(a_i) + (WORD_W+1)'(b_i);
    assign diff_w = (WORD_W+1)'(a_i) - (WORD_W+1)'(b_i);
    // The product fits in a word when every bit above bit 30 is a sign copy.
    assign mul_fits = (&prod_o[2*WORD_W-1:WORD_W-1]) | ~(|prod_o[2*WORD_W-1:WORD_W-1]);

    // One guard bit is enough for add/sub: overflow iff the top two bits differ.
    function automatic logic [WORD_W-1:0] clip_guard(input logic signed [WORD_W:0] v);
        if (v[WORD_W] == v[WORD_W-1]) return v[WORD_W-1:0];
        return v[WORD_W] ? SAT_MIN : SAT_MAX;
    endfunction

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD:  res_o = clip_guard(sum_w);
            OP_SUB:  res_o = clip_guard(diff_w);
            OP_MUL:  res_o = mul_fits ? prod_o[WORD_W-1:0]
                                      : (prod_o[2*WORD_W-1] ? SAT_MIN : SAT_MAX);
            default: res_o = '0;
        endcase
    end
`else
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD:  res_o = a_i + b_i;
            OP_SUB:  res_o = a_i - b_i;
            OP_MUL:  res_o = prod_o[WORD_W-1:0];
            default: res_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/vcu_vec_engine.sv
// rtl/vcu_vec_engine.sv - vector engine: load A/B from BRAM, lane-parallel execute, write back
// Ports: clk; RESET async active-high; memWRTDone start/done handshake; op operation code;
//        bram (master side of vcu_vec_engine_if); busy high outside IDLE; done high in DONE.
// Macro: VCU_SATURATE_EN saturates lane results and the dot accumulator; otherwise results wrap.
module vcu_vec_engine
    import vcu_pkg::*;
#(
    parameter int NoOfElem  = 16,
    parameter int wordSize  = 32,
    parameter int memDepthC = 32,
    parameter int RD_LAT    = 1,
    parameter int BASE_A    = 0,
    parameter int BASE_B    = 16,
    parameter int BASE_R    = 32
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    memWRTDone,
    input  logic [1:0]              op,
    vcu_vec_engine_if.master        bram,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W  = memDepthC - 2;
    localparam int LANE_W = $clog2(NoOfElem);
    localparam int CNT_W  = $clog2(NoOfElem + RD_LAT) + 1;
    localparam int ACC_W  = acc_width(NoOfElem, wordSize);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(NoOfElem);
    localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(NoOfElem + RD_LAT - 1);

    vcu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    vcu_op_e            op_q;

    logic [wordSize-1:0]        a_q [NoOfElem];
    logic [wordSize-1:0]        b_q [NoOfElem];
    logic [wordSize-1:0]        r_q [NoOfElem];
    logic [WORD_W-1:0]          lane_res  [NoOfElem];
    logic signed [2*WORD_W-1:0] lane_prod [NoOfElem];
    logic signed [ACC_W-1:0]    acc;
    logic [WORD_W-1:0]          dot_res;

    logic [IDX_W-1:0]    widx;
    logic [LANE_W-1:0]   cap_lane;
    logic [LANE_W-1:0]   out_lane;
    logic                capture;
    logic                en;
    logic [3:0]          wren;
    logic [wordSize-1:0] wdata;
    logic [CNT_W-1:0]    store_last;

    // In a load state cnt_q counts issue cycles; the word for lane i returns RD_LAT cycles later.
    assign capture  = (cnt_q >= LAT_CNT);
    assign cap_lane = LANE_W'(cnt_q - LAT_CNT);
    assign out_lane = cnt_q[LANE_W-1:0];

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && memWRTDone) begin
                op_q <= vcu_op_e'(op);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en         = 1'b0;
        wren       = '0;
        wdata      = '0;
        widx       = '0;
        store_last = (op_q == OP_DOT) ? '0 : N_CNT - ONE;
        case (state_q)
            ST_IDLE: begin
                if (memWRTDone) state_d = ST_LOAD_A;
            end
            ST_LOAD_A, ST_LOAD_B: begin
                if (cnt_q < N_CNT) begin
                    en   = 1'b1;
                    widx = IDX_W'(state_q == ST_LOAD_A ? BASE_A : BASE_B) + IDX_W'(cnt_q);
                end
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_EXEC;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_EXEC: state_d = ST_STORE;
            ST_STORE: begin
                en    = 1'b1;
                wren  = 4'hF;
                widx  = IDX_W'(BASE_R) + IDX_W'(cnt_q);
                wdata = r_q[out_lane];
                if (cnt_q == store_last) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_DONE: begin
                if (!memWRTDone) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane storage carries no reset; it is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD_A && capture) a_q[cap_lane] <= bram.BRAMdataIn;
        if (state_q == ST_LOAD_B && capture) b_q[cap_lane] <= bram.BRAMdataIn;
        if (state_q == ST_EXEC) begin
            for (int i = 0; i < NoOfElem; i++) r_q[i] <= lane_res[i];
            if (op_q == OP_DOT) r_q[0] <= dot_res;
        end
    end

    for (genvar g = 0; g < NoOfElem; g++) begin : g_lane
        vcu_lane_alu u_alu (
            .a_i    (a_q[g]),
            .b_i    (b_q[g]),
            .op_i   (op_q),
            .res_o  (lane_res[g]),
            .prod_o (lane_prod[g])
        );
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NoOfElem; i++) acc = acc + ACC_W'(lane_prod[i]);
    end

`ifdef VCU_SATURATE_EN
    logic acc_fits;
    assign acc_fits = (&acc[ACC_W-1:WORD_W-1]) | ~(|acc[ACC_W-1:WORD_W-1]);
    assign dot_res  = acc_fits ? acc[WORD_W-1:0] : (acc[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
    logic unused_acc_hi;
    assign dot_res       = acc[WORD_W-1:0];
    assign unused_acc_hi = ^acc[ACC_W-1:WORD_W];
`endif

    assign bram.BRAMENMEM    = en;
    assign bram.BRAMWREN     = wren;
    assign bram.BRAMDataOut  = wdata;
    assign bram.BRAMaddrByte = {widx, 2'b00};
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);

endmodule

// File: tb/tb_vcu_vec_engine.sv
// tb/tb_vcu_vec_engine.sv - scoreboard bench for vcu_vec_engine at read latency 1 and 2
`timescale 1ns/1ps
module tb_vcu_vec_engine;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [1:0]  opv0 = 2'b00;
    logic [1:0]  opv1 = 2'b00;
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [1:0]  load = 2'b00;
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          wr_cnt [2];
    logic [31:0] img0 [64];
    logic [31:0] img1 [64];
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] rd0, rd1a, rd1b;
    wr_t         sbq0 [$];
    wr_t         sbq1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vcu_vec_engine_if #(.wordSize(32), .memDepthC(32)) b0 ();
    vcu_vec_engine_if #(.wordSize(32), .memDepthC(32)) b1 ();

    vcu_vec_engine #(.RD_LAT(1)) dut0 (
        .clk(clk), .RESET(rst), .memWRTDone(start[0]), .op(opv0),
        .bram(b0), .busy(busy_w[0]), .done(done_w[0])
    );
    vcu_vec_engine #(.RD_LAT(2)) dut1 (
        .clk(clk), .RESET(rst), .memWRTDone(start[1]), .op(opv1),
        .bram(b1), .busy(busy_w[1]), .done(done_w[1])
    );

    // Block RAM models: latency 1 for dut0, latency 2 for dut1.
    always @(posedge clk) begin
        if (load[0]) begin
            for (int i = 0; i < 64; i++) mem0[i] <= img0[i];
        end else if (b0.BRAMENMEM && b0.BRAMWREN == 4'hF) begin
            mem0[b0.BRAMaddrByte[7:2]] <= b0.BRAMDataOut;
        end
        if (b0.BRAMENMEM) rd0 <= mem0[b0.BRAMaddrByte[7:2]];
        if (load[1]) begin
            for (int i = 0; i < 64; i++) mem1[i] <= img1[i];
        end else if (b1.BRAMENMEM && b1.BRAMWREN == 4'hF) begin
            mem1[b1.BRAMaddrByte[7:2]] <= b1.BRAMDataOut;
        end
        if (b1.BRAMENMEM) rd1a <= mem1[b1.BRAMaddrByte[7:2]];
        rd1b <= rd1a;
    end
    assign b0.BRAMdataIn = rd0;
    assign b1.BRAMdataIn = rd1b;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fit32(input logic signed [71:0] v);
`ifdef VCU_SATURATE_EN
        if (v > 72'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -72'sd2147483648) return 32'h8000_0000;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] lane_model(input logic [1:0] opc,
                                               input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [71:0] x, y;
        x = a;
        y = b;
        case (opc)
            2'd0:    return fit32(x + y);
            2'd1:    return fit32(x - y);
            default: return fit32(x * y);
        endcase
    endfunction

    task automatic push_exp(input int k, input logic [1:0] opc);
        wr_t                e;
        logic signed [71:0] s, x, y;
        logic signed [31:0] a, b;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            a = (k == 0) ? img0[i]      : img1[i];
            b = (k == 0) ? img0[16 + i] : img1[16 + i];
            if (opc == 2'd3) begin
                x = a;
                y = b;
                s = s + x * y;
            end else begin
                e.idx  = 32 + i;
                e.data = lane_model(opc, a, b);
                if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
            end
        end
        if (opc == 2'd3) begin
            e.idx  = 32;
            e.data = fit32(s);
            if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
        end
    endtask

    task automatic observe(input int k, input logic [3:0] wren, input logic en,
                           input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        int  depth;
        if (wren == 4'h0) return;
        wr_cnt[k]++;
        depth = (k == 0) ? sbq0.size() : sbq1.size();
        if (depth == 0) begin
            check_eq($sformatf("dut%0d_unexpected_wr", k), 64'(wren), 64'h0);
            return;
        end
        if (k == 0) e = sbq0.pop_front(); else e = sbq1.pop_front();
        check_eq($sformatf("dut%0d_wr_addr", k), 64'(addr), 64'(e.idx * 4));
        check_eq($sformatf("dut%0d_wr_data[%0d]", k, e.idx), 64'(data), 64'(e.data));
        check_eq($sformatf("dut%0d_wr_wren", k), 64'(wren), 64'hF);
        check_eq($sformatf("dut%0d_wr_en", k), 64'(en), 64'h1);
    endtask

    always @(negedge clk) begin
        observe(0, b0.BRAMWREN, b0.BRAMENMEM, b0.BRAMaddrByte, b0.BRAMDataOut);
        observe(1, b1.BRAMWREN, b1.BRAMENMEM, b1.BRAMaddrByte, b1.BRAMDataOut);
    end

    task automatic load_img(input int k);
        @(posedge clk); #1; load[k] = 1'b1;
        @(posedge clk); #1; load[k] = 1'b0;
    endtask

    task automatic set_op(input int k, input logic [1:0] v);
        if (k == 0) opv0 = v; else opv1 = v;
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        if (k == 0) begin
            check_eq({tag, "_wren"}, 64'(b0.BRAMWREN), 64'h0);
            check_eq({tag, "_en"},   64'(b0.BRAMENMEM), 64'h0);
            check_eq({tag, "_addr"}, 64'(b0.BRAMaddrByte), 64'h0);
            check_eq({tag, "_dout"}, 64'(b0.BRAMDataOut), 64'h0);
        end else begin
            check_eq({tag, "_wren"}, 64'(b1.BRAMWREN), 64'h0);
            check_eq({tag, "_en"},   64'(b1.BRAMENMEM), 64'h0);
            check_eq({tag, "_addr"}, 64'(b1.BRAMaddrByte), 64'h0);
            check_eq({tag, "_dout"}, 64'(b1.BRAMDataOut), 64'h0);
        end
        check_eq({tag, "_busy"}, 64'(busy_w[k]), 64'h0);
        check_eq({tag, "_done"}, 64'(done_w[k]), 64'h0);
    endtask

    // Start one operation, disturb op/memWRTDone mid-run, wait for done and check timing.
    task automatic do_run(input int k, input logic [1:0] opc, input int lat, input string tag);
        int t0, base, nwr, depth;
        bit seen;
        nwr = (opc == 2'd3) ? 1 : 16;
        push_exp(k, opc);
        base = wr_cnt[k];
        @(posedge clk); #1;
        set_op(k, opc);
        start[k] = 1'b1;
        t0 = cyc;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (c == 3) set_op(k, ~opc);
            if (c == 4) start[k] = 1'b0;
            if (c == 6) start[k] = 1'b1;
            if (done_w[k]) seen = 1'b1;
        end
        depth = (k == 0) ? sbq0.size() : sbq1.size();
        check_eq({tag, "_done_seen"},  64'(seen), 64'h1);
        check_eq({tag, "_done_cycle"}, 64'(cyc - t0), 64'(1 + 2 * (16 + lat) + 1 + nwr));
        check_eq({tag, "_writes"},     64'(wr_cnt[k] - base), 64'(nwr));
        check_eq({tag, "_busy_done"},  64'(busy_w[k]), 64'h1);
        check_eq({tag, "_sb_left"},    64'(depth), 64'h0);
    endtask

    task automatic release_start(input int k, input string tag);
        @(posedge clk); #1; start[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_rel_done"}, 64'(done_w[k]), 64'h0);
        check_eq({tag, "_rel_busy"}, 64'(busy_w[k]), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int  wbase;
        bit  found;
        wr_cnt[0] = 0;
        wr_cnt[1] = 0;
        for (int i = 0; i < 64; i++) begin
            img0[i] = '0;
            img1[i] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset1");
        @(posedge clk); #1; rst = 1'b0;

        // add: A[i]=i, B[i]=100
        for (int i = 0; i < 16; i++) begin
            img0[i]      = 32'(i);
            img0[16 + i] = 32'd100;
        end
        load_img(0);
        do_run(0, 2'd0, 1, "add");

        // memWRTDone held high: no re-run, done stays up
        wbase = wr_cnt[0];
        repeat (10) @(negedge clk);
        check_eq("hold_done", 64'(done_w[0]), 64'h1);
        check_eq("hold_no_writes", 64'(wr_cnt[0] - wbase), 64'h0);
        release_start(0, "add");
        do_run(0, 2'd0, 1, "add_again");
        release_start(0, "add_again");

        // sub with boundary lane 0
        for (int i = 0; i < 32; i++) img0[i] = $urandom;
        img0[0]  = 32'h8000_0000;
        img0[16] = 32'h0000_0001;
        load_img(0);
        do_run(0, 2'd1, 1, "sub");
        release_start(0, "sub");

        // dot: 2*3 over 16 lanes
        for (int i = 0; i < 16; i++) begin
            img0[i]      = 32'd2;
            img0[16 + i] = 32'd3;
        end
        load_img(0);
        do_run(0, 2'd3, 1, "dot");
        release_start(0, "dot");

        // RD_LAT=2 mul: A[i]=B[i]=i
        for (int i = 0; i < 16; i++) begin
            img1[i]      = 32'(i);
            img1[16 + i] = 32'(i);
        end
        load_img(1);
        do_run(1, 2'd2, 2, "mul_lat2");
        release_start(1, "mul_lat2");

        // RD_LAT=2 random operands, every op
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 32; i++) img1[i] = $urandom;
            load_img(1);
            do_run(1, 2'(o), 2, $sformatf("rnd_op%0d", o));
            release_start(1, $sformatf("rnd_op%0d", o));
        end

        // Reset asserted while storing lane 5
        for (int i = 0; i < 16; i++) begin
            img0[i]      = 32'(i);
            img0[16 + i] = 32'd100;
        end
        load_img(0);
        push_exp(0, 2'd0);
        @(posedge clk); #1;
        opv0 = 2'd0;
        start[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (b0.BRAMWREN != 4'h0 && b0.BRAMaddrByte == 32'((32 + 5) * 4)) found = 1'b1;
        end
        check_eq("rst_reached_store5", 64'(found), 64'h1);
        rst = 1'b1;
        start[0] = 1'b0;
        #1;
        check_idle_outputs(0, "rst_mid");
        sbq0.delete();
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", 64'(busy_w[0]), 64'h0);
        do_run(0, 2'd0, 1, "post_rst_add");
        release_start(0, "post_rst_add");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
